// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encodings, board bit-period constants
// and a frame-length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_t;

    localparam int BOARD_CLK_HZ = 100_000_000;
    localparam int CPB_115200   = (BOARD_CLK_HZ + 115200 / 2) / 115200;
    localparam int CPB_9600     = (BOARD_CLK_HZ + 9600 / 2) / 9600;

    // Clock cycles for one complete frame on the line.
    function automatic int frame_cycles(input int clk_per_bit, input int data_bits,
                                        input int stop_bits, input int parity_bits);
        return (1 + data_bits + parity_bits + stop_bits) * clk_per_bit;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered occupancy count; shared by the UART TX path
// and intended for reuse on the RX side.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: the storage array has no reset; a slot is never read before it is
    // written, so clearing it would only add reset fan-out to every bit.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter fed by an internal TX FIFO (valid/ready writes).
// Define UART_TX_PARITY_EN to insert a parity bit between data and stop bits.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 1040,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int PARITY_ODD  = 0
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [DATA_BITS-1:0]          wdata,
    input  logic                          wvalid,
    output logic                          wready,
    output logic                          txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int             CW        = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

    if (CLK_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_tx_param: illegal parameter combination");
    end

    tx_state_t            state;
    logic [CW-1:0]        baud_cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 stop_end;

    assign wready   = !fifo_full;
    assign push     = wvalid && wready;
    assign bit_end  = (baud_cnt == CNT_LAST);
    assign stop_end = (state == S_STOP) && bit_end && (bit_idx == STOP_LAST);
    // Popping at the last stop-bit edge is what gives back-to-back frames no idle gap.
    assign pop      = !fifo_empty && ((state == S_IDLE) || stop_end);

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef UART_TX_PARITY_EN
    logic parity;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)    parity <= 1'b0;
        else if (pop) parity <= (^fifo_rdata) ^ PARITY_ODD[0];
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            if (pop) begin
                shreg    <= fifo_rdata;
                txd      <= 1'b0;
                baud_cnt <= '0;
                state    <= S_START;
                tx_busy  <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        baud_cnt <= '0;
                        tx_busy  <= push;
                    end
                    S_START: if (bit_end) begin
                        txd     <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end
                    S_DATA: if (bit_end) begin
                        if (bit_idx == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                            txd   <= parity;
                            state <= S_PARITY;
`else
                            txd     <= 1'b1;
                            bit_idx <= '0;
                            state   <= S_STOP;
`endif
                        end else begin
                            txd     <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    S_PARITY: if (bit_end) begin
                        txd     <= 1'b1;
                        bit_idx <= '0;
                        state   <= S_STOP;
                    end
`endif
                    S_STOP: if (bit_end) begin
                        if (bit_idx == STOP_LAST) begin
                            state   <= S_IDLE;
                            tx_busy <= push;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        txd   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations driven by directed writes; line
// monitors decode each frame and compare it against a per-instance scoreboard.
module tb_uart_tx_param;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] wd0  = '0;
    logic [6:0] wd1  = '0;
    logic [7:0] wd2  = '0;
    logic       wv0  = 1'b0;
    logic       wv1  = 1'b0;
    logic       wv2  = 1'b0;
    logic       wr0, wr1, wr2;
    logic       txd0, txd1, txd2;
    logic       bz0, bz1, bz2;
    logic [2:0] cnt0, cnt1, cnt2;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_wr  = 0;

    logic [8:0] exp_q     [3][$];
    int         start_cyc [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_param #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)) dut (
        .clk(clk), .rstn(rstn), .wdata(wd0), .wvalid(wv0), .wready(wr0),
        .txd(txd0), .tx_busy(bz0), .fifo_count(cnt0));

    uart_tx_param #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(0)) dut2 (
        .clk(clk), .rstn(rstn), .wdata(wd1), .wvalid(wv1), .wready(wr1),
        .txd(txd1), .tx_busy(bz1), .fifo_count(cnt1));

    uart_tx_param #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(1)) dut3 (
        .clk(clk), .rstn(rstn), .wdata(wd2), .wvalid(wv2), .wready(wr2),
        .txd(txd2), .tx_busy(bz2), .fifo_count(cnt2));

    function automatic int dbits(input int sel);
        return (sel == 1) ? 7 : 8;
    endfunction

    function automatic int sbits(input int sel);
        return (sel == 1) ? 2 : 1;
    endfunction

    function automatic int flen(input int sel);
        return (1 + dbits(sel) + PB + sbits(sel)) * CPB;
    endfunction

    function automatic logic line(input int sel);
        case (sel)
            0:       return txd0;
            1:       return txd1;
            default: return txd2;
        endcase
    endfunction

    // Expected level of bit slot b (0 = start) of a frame carrying d.
    function automatic logic exp_bit(input int sel, input logic [8:0] d, input int b);
        int   nd;
        logic par;
        nd  = dbits(sel);
        par = (sel == 2);
        if (b == 0) return 1'b0;
        if (b <= nd) return d[b-1];
        for (int i = 0; i < nd; i++) par = par ^ d[i];
        if (PB == 1 && b == nd + 1) return par;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input int sel, input logic [8:0] d, input bit accept);
        case (sel)
            0:       begin wd0 = d[7:0]; wv0 = 1'b1; end
            1:       begin wd1 = d[6:0]; wv1 = 1'b1; end
            default: begin wd2 = d[7:0]; wv2 = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        wv0 = 1'b0;
        wv1 = 1'b0;
        wv2 = 1'b0;
        last_wr = cyc;
        if (accept) exp_q[sel].push_back(d);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_frames(input int sel, input int n);
        for (int i = 0; i < 600 && start_cyc[sel].size() < n; i++) @(negedge clk);
        check($sformatf("sel%0d frames_seen", sel), start_cyc[sel].size(), n);
    endtask

    // Decodes one line: every CPB-cycle bit slot is sampled on all its falling clock edges.
    task automatic monitor(input int sel);
        logic [8:0] d;
        logic [3:0] smp;
        int         t0;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (rstn && line(sel) == 1'b0) begin
                t0 = cyc;
                d  = '0;
                check($sformatf("sel%0d frame_expected", sel), 32'(exp_q[sel].size() != 0), 1);
                if (exp_q[sel].size() != 0) d = exp_q[sel].pop_front();
                aborted = 1'b0;
                for (int b = 0; b < flen(sel) / CPB && !aborted; b++) begin
                    smp = '0;
                    for (int s = 0; s < CPB; s++) begin
                        if (b != 0 || s != 0) @(negedge clk);
                        if (!rstn) aborted = 1'b1;
                        smp[s] = line(sel);
                    end
                    if (!aborted)
                        check($sformatf("sel%0d data%0h bit%0d", sel, d, b), smp, {4{exp_bit(sel, d, b)}});
                end
                if (!aborted) start_cyc[sel].push_back(t0);
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int fl;
        int nf;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst txd", txd0, 1);
        check("rst busy", bz0, 0);
        check("rst wready", wr0, 1);
        check("rst count", cnt0, 0);
        check("rst txd2", txd1, 1);
        check("rst count2", cnt1, 0);
        check("rst wready3", wr2, 1);
        check("rst busy3", bz2, 0);
        check("rst count3", cnt2, 0);
        @(posedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);

        // Single frame: latency, bit timing and busy fall
        fl = flen(0);
        write_word(0, 9'h0A5, 1'b1);
        n = last_wr;
        check("t1 count_after_push", cnt0, 1);
        check("t1 busy_after_push", bz0, 1);
        check("t1 txd_before_pop", txd0, 1);
        wait_cyc(n + fl);
        check("t1 busy_last_stop", bz0, 1);
        wait_cyc(n + fl + 1);
        check("t1 busy_frame_end", bz0, 0);
        check("t1 txd_frame_end", txd0, 1);
        check("t1 count_frame_end", cnt0, 0);
        wait_frames(0, 1);
        check("t1 start_latency", start_cyc[0][0], n + 1);

        // Fill the FIFO behind a lead frame, drop a write while full, zero-gap frames
        write_word(0, 9'h0C3, 1'b1);
        n = last_wr;
        write_word(0, 9'h000, 1'b1);
        write_word(0, 9'h0FF, 1'b1);
        write_word(0, 9'h03C, 1'b1);
        write_word(0, 9'h081, 1'b1);
        check("t2 wready_full", wr0, 0);
        check("t2 count_full", cnt0, 4);
        write_word(0, 9'h077, 1'b0);
        check("t2 count_after_drop", cnt0, 4);
        wait_cyc(n + fl);
        check("t2 wready_before_pop", wr0, 0);
        wait_cyc(n + fl + 1);
        check("t2 wready_after_pop", wr0, 1);
        check("t2 count_after_pop", cnt0, 3);
        wait_cyc(n + 5 * fl + 1);
        check("t2 busy_end", bz0, 0);
        wait_frames(0, 6);
        for (int k = 0; k < 5; k++)
            check($sformatf("t2 frame%0d_start", k), start_cyc[0][1 + k], n + 1 + k * fl);
        repeat (20) @(negedge clk);
        check("t2 no_extra_frame", start_cyc[0].size(), 6);
        check("t2 scoreboard_empty", exp_q[0].size(), 0);

        // Seven data bits, two stop bits
        write_word(1, 9'h055, 1'b1);
        n = last_wr;
        wait_cyc(n + flen(1));
        check("t3 busy_last_stop", bz1, 1);
        wait_cyc(n + flen(1) + 1);
        check("t3 busy_end", bz1, 0);
        wait_frames(1, 1);
        check("t3 start_latency", start_cyc[1][0], n + 1);

        // Parity frames (plain frames when the parity feature is not built in)
        write_word(0, 9'h007, 1'b1);
        n = last_wr;
        wait_cyc(n + fl + 1);
        check("t4 even_busy_end", bz0, 0);
        wait_frames(0, 7);
        check("t4 even_start", start_cyc[0][6], n + 1);
        write_word(2, 9'h003, 1'b1);
        n = last_wr;
        wait_cyc(n + flen(2));
        check("t4 odd_busy_last_stop", bz2, 1);
        wait_cyc(n + flen(2) + 1);
        check("t4 odd_busy_end", bz2, 0);
        wait_frames(2, 1);
        check("t4 odd_start", start_cyc[2][0], n + 1);

        // Asynchronous reset in the middle of the data bits
        write_word(0, 9'h0F0, 1'b1);
        n = last_wr;
        write_word(0, 9'h00F, 1'b1);
        check("t5 count_before_reset", cnt0, 1);
        wait_cyc(n + 14);
        check("t5 txd_mid_data", txd0, 0);
        #2 rstn = 1'b0;
        #1;
        check("t5 txd_in_reset", txd0, 1);
        check("t5 count_in_reset", cnt0, 0);
        check("t5 busy_in_reset", bz0, 0);
        check("t5 wready_in_reset", wr0, 1);
        @(posedge clk);
        @(posedge clk);
        #2 rstn = 1'b1;
        exp_q[0].delete();
        repeat (6) @(negedge clk);
        nf = start_cyc[0].size();
        write_word(0, 9'h096, 1'b1);
        n = last_wr;
        wait_cyc(n + fl + 1);
        check("t5 busy_end", bz0, 0);
        wait_frames(0, nf + 1);
        check("t5 clean_frame_start", start_cyc[0][nf], n + 1);

        // Push and pop on the same edge with two entries queued
        nf = start_cyc[0].size();
        write_word(0, 9'h011, 1'b1);
        n = last_wr;
        write_word(0, 9'h022, 1'b1);
        write_word(0, 9'h033, 1'b1);
        wait_cyc(n + fl);
        check("t6 count_before_swap", cnt0, 2);
        write_word(0, 9'h044, 1'b1);
        check("t6 count_same_edge", cnt0, 2);
        wait_cyc(n + 4 * fl + 1);
        check("t6 busy_end", bz0, 0);
        wait_frames(0, nf + 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("t6 frame%0d_start", k), start_cyc[0][nf + k], n + 1 + k * fl);
        check("t6 scoreboard_empty", exp_q[0].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
